// File: rtl/carpici_pkg.sv
// Shared definitions for the multiplier arbiter (carpici_hakemi) and the
// shared two-bit-per-step multiplier it sequences.
//   durum_t          : arbiter FSM state encoding
//   CARPICI_GECIKME  : cycles from request acceptance to first response valid
//   CARPICI_ADIM     : number of two-bit steps the multiplier takes (32 / 2)
//   kismi_carpim     : partial product of a multiplicand and one radix-4 digit
package carpici_pkg;

    typedef enum logic [1:0] {
        BOS    = 2'd0,
        BASLAT = 2'd1,
        BEKLE  = 2'd2,
        YANIT  = 2'd3
    } durum_t;

    localparam int CARPICI_GECIKME = 19;
    localparam int CARPICI_ADIM    = 16;

    // Multiplicand times a radix-4 digit, built from shifts and one add.
    function automatic logic [63:0] kismi_carpim(input logic [63:0] kat,
                                                 input logic [1:0]  rakam);
        logic [63:0] sonuc;
        case (rakam)
            2'd0:    sonuc = 64'd0;
            2'd1:    sonuc = kat;
            2'd2:    sonuc = kat << 1;
            2'd3:    sonuc = kat + (kat << 1);
            default: sonuc = 64'd0;
        endcase
        return sonuc;
    endfunction

endpackage

// File: rtl/carpici_hakemi_rr_secici.sv
// rr_secici: N-wide round-robin priority picker.
// The lowest requesting index at or above the pointer wins; the search
// wraps from N-1 back to 0.
// Ports:
//   istek    in  N   request vector
//   isaretci in  IW  round-robin pointer (0..N-1)
//   izin     out N   one-hot grant (zero when no request)
//   izin_idx out IW  index of the granted requester
//   herhangi out 1   at least one request present
module rr_secici #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  istek,
    input  logic [IW-1:0] isaretci,
    output logic [N-1:0]  izin,
    output logic [IW-1:0] izin_idx,
    output logic          herhangi
);

    int aday;

    // Walk the requesters starting at the pointer and keep the first hit.
    always_comb begin
        izin     = '0;
        izin_idx = '0;
        herhangi = 1'b0;
        aday     = 0;
        for (int i = 0; i < N; i++) begin
            aday = int'(isaretci) + i;
            if (aday >= N) begin
                aday = aday - N;
            end else begin
                aday = aday;
            end
            if (!herhangi && istek[aday]) begin
                herhangi   = 1'b1;
                izin[aday] = 1'b1;
                izin_idx   = IW'(aday);
            end else begin
                herhangi = herhangi;
            end
        end
    end

endmodule

// File: rtl/iki_bit_adimli_carpici.sv
// iki_bit_adimli_carpici: 32x32 -> 64 multiplier retiring two multiplier bits
// per clock (16 steps). Operands are converted to magnitudes at start; the
// sign of the result is applied combinationally from the live a_g/b_g, so the
// caller must hold the operands until the result is taken.
// Ports:
//   clk         in  1   clock
//   rst_g       in  1   synchronous, active-high reset
//   istek       in  1   start pulse (one cycle)
//   a_g, b_g    in  32  operands
//   a_isaretli  in  1   a is two's complement
//   b_isaretli  in  1   b is two's complement
//   sonuc       out 64  product, valid while bitti is high
//   bitti       out 1   one-cycle done strobe
module iki_bit_adimli_carpici
    import carpici_pkg::*;
(
    input  logic        clk,
    input  logic        rst_g,
    input  logic        istek,
    input  logic [31:0] a_g,
    input  logic [31:0] b_g,
    input  logic        a_isaretli,
    input  logic        b_isaretli,
    output logic [63:0] sonuc,
    output logic        bitti
);

    logic [63:0] birikim;
    logic [63:0] kat;
    logic [31:0] carpan;
    logic [4:0]  adim;
    logic        calisiyor;
    logic        negatif;

    function automatic logic [31:0] mutlak(input logic [31:0] x, input logic isaretli);
        logic [31:0] m;
        if (isaretli && x[31]) begin
            m = ~x + 32'd1;
        end else begin
            m = x;
        end
        return m;
    endfunction

    // Shift-and-add datapath: one radix-4 digit of the multiplier per cycle.
    always_ff @(posedge clk) begin
        if (rst_g) begin
            birikim   <= 64'd0;
            kat       <= 64'd0;
            carpan    <= 32'd0;
            adim      <= 5'd0;
            calisiyor <= 1'b0;
            bitti     <= 1'b0;
        end else if (istek) begin
            birikim   <= 64'd0;
            kat       <= {32'd0, mutlak(a_g, a_isaretli)};
            carpan    <= mutlak(b_g, b_isaretli);
            adim      <= 5'd0;
            calisiyor <= 1'b1;
            bitti     <= 1'b0;
        end else if (calisiyor) begin
            birikim   <= birikim + kismi_carpim(kat, carpan[1:0]);
            kat       <= kat << 2;
            carpan    <= carpan >> 2;
            adim      <= adim + 5'd1;
            calisiyor <= (adim != 5'(CARPICI_ADIM - 1));
            bitti     <= (adim == 5'(CARPICI_ADIM - 1));
        end else begin
            bitti     <= 1'b0;
        end
    end

    assign negatif = (a_isaretli & a_g[31]) ^ (b_isaretli & b_g[31]);
    assign sonuc   = negatif ? (~birikim + 64'd1) : birikim;

endmodule

// File: rtl/carpici_hakemi.sv
// carpici_hakemi: round-robin arbiter/sequencer sharing one
// iki_bit_adimli_carpici among ISTEKCI_SAYISI requesters.
// Accepts one operation in BOS, pulses the multiplier start in BASLAT, waits
// in BEKLE (with timeout) and returns the product to the winner in YANIT.
// Ports:
//   clk              in  1     clock
//   rst_g            in  1     asynchronous active-low reset
//   istek_gecerli    in  N     per-requester operand valid
//   istek_hazir      out N     accept strobe (one-hot or zero)
//   istek_a/istek_b  in  32*N  operands, slot k at [32k+31:32k]
//   istek_a_isaretli in  N     operand A signed
//   istek_b_isaretli in  N     operand B signed
//   yanit_gecerli    out N     result valid (one-hot or zero)
//   yanit_hazir      in  N     result ready
//   yanit_sonuc      out 64    product
//   yanit_hata       out 1     timeout flag
//   mesgul           out 1     high outside BOS
module carpici_hakemi
    import carpici_pkg::*;
#(
    parameter int ISTEKCI_SAYISI = 4,
    parameter int ZAMAN_ASIMI    = 31
) (
    input  logic                        clk,
    input  logic                        rst_g,
    input  logic [ISTEKCI_SAYISI-1:0]   istek_gecerli,
    output logic [ISTEKCI_SAYISI-1:0]   istek_hazir,
    input  logic [32*ISTEKCI_SAYISI-1:0] istek_a,
    input  logic [32*ISTEKCI_SAYISI-1:0] istek_b,
    input  logic [ISTEKCI_SAYISI-1:0]   istek_a_isaretli,
    input  logic [ISTEKCI_SAYISI-1:0]   istek_b_isaretli,
    output logic [ISTEKCI_SAYISI-1:0]   yanit_gecerli,
    input  logic [ISTEKCI_SAYISI-1:0]   yanit_hazir,
    output logic [63:0]                 yanit_sonuc,
    output logic                        yanit_hata,
    output logic                        mesgul
);

    localparam int N  = ISTEKCI_SAYISI;
    localparam int IW = $clog2(N);
    // Timeout fires on the ZAMAN_ASIMI-th BEKLE cycle (counter starts at 0).
    localparam logic [7:0] SAYAC_SON = 8'(ZAMAN_ASIMI - 1);

    durum_t        durum;
    durum_t        durum_sonraki;
    logic [IW-1:0] oncelik;
    logic [IW-1:0] secili;
    logic [31:0]   a_r;
    logic [31:0]   b_r;
    logic          a_is_r;
    logic          b_is_r;
    logic [63:0]   sonuc_r;
    logic          hata_r;
    logic [7:0]    sayac;
    logic          carpici_rst;
    logic          carpici_istek;
    logic [63:0]   carpici_sonuc;
    logic          carpici_bitti;

    logic [N-1:0]  secici_izin;
    logic [IW-1:0] secici_idx;
    logic          secici_var;
    logic [31:0]   secim_a;
    logic [31:0]   secim_b;
    logic          secim_a_is;
    logic          secim_b_is;

    rr_secici #(.N(N)) u_secici (
        .istek    (istek_gecerli),
        .isaretci (oncelik),
        .izin     (secici_izin),
        .izin_idx (secici_idx),
        .herhangi (secici_var)
    );

    iki_bit_adimli_carpici u_carpici (
        .clk        (clk),
        .rst_g      (carpici_rst),
        .istek      (carpici_istek),
        .a_g        (a_r),
        .b_g        (b_r),
        .a_isaretli (a_is_r),
        .b_isaretli (b_is_r),
        .sonuc      (carpici_sonuc),
        .bitti      (carpici_bitti)
    );

    // Operand mux driven by the one-hot grant.
    always_comb begin
        secim_a    = 32'd0;
        secim_b    = 32'd0;
        secim_a_is = 1'b0;
        secim_b_is = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (secici_izin[k]) begin
                secim_a    = istek_a[32*k +: 32];
                secim_b    = istek_b[32*k +: 32];
                secim_a_is = istek_a_isaretli[k];
                secim_b_is = istek_b_isaretli[k];
            end else begin
                secim_a = secim_a;
            end
        end
    end

    // Next-state logic plus the accept strobe and multiplier start pulse.
    always_comb begin
        durum_sonraki = durum;
        istek_hazir   = '0;
        carpici_istek = 1'b0;
        case (durum)
            BOS: begin
                if (secici_var) begin
                    istek_hazir   = secici_izin;
                    durum_sonraki = BASLAT;
                end else begin
                    durum_sonraki = BOS;
                end
            end
            BASLAT: begin
                carpici_istek = 1'b1;
                durum_sonraki = BEKLE;
            end
            BEKLE: begin
                if (carpici_bitti || (sayac == SAYAC_SON)) begin
                    durum_sonraki = YANIT;
                end else begin
                    durum_sonraki = BEKLE;
                end
            end
            YANIT: begin
                if (yanit_hazir[secili]) begin
                    durum_sonraki = BOS;
                end else begin
                    durum_sonraki = YANIT;
                end
            end
            default: durum_sonraki = BOS;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_g) begin
        if (!rst_g) begin
            durum <= BOS;
        end else begin
            durum <= durum_sonraki;
        end
    end

    // Multiplier reset: held while rst_g is low, dropped on the first edge after release.
    always_ff @(posedge clk or negedge rst_g) begin
        if (!rst_g) begin
            carpici_rst <= 1'b1;
        end else begin
            carpici_rst <= 1'b0;
        end
    end

    // Operand latch, timeout counter, result capture and round-robin pointer.
    always_ff @(posedge clk or negedge rst_g) begin
        if (!rst_g) begin
            oncelik <= '0;
            secili  <= '0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            a_is_r  <= 1'b0;
            b_is_r  <= 1'b0;
            sonuc_r <= 64'd0;
            hata_r  <= 1'b0;
            sayac   <= 8'd0;
        end else begin
            case (durum)
                BOS: begin
                    if (secici_var) begin
                        secili <= secici_idx;
                        a_r    <= secim_a;
                        b_r    <= secim_b;
                        a_is_r <= secim_a_is;
                        b_is_r <= secim_b_is;
                    end else begin
                        secili <= secili;
                    end
                end
                BASLAT: begin
                    sayac <= 8'd0;
                end
                BEKLE: begin
                    if (carpici_bitti) begin
                        sonuc_r <= carpici_sonuc;
                        hata_r  <= 1'b0;
                    end else if (sayac == SAYAC_SON) begin
                        sonuc_r <= 64'd0;
                        hata_r  <= 1'b1;
                    end else begin
                        sayac <= sayac + 8'd1;
                    end
                end
                YANIT: begin
                    if (yanit_hazir[secili]) begin
                        oncelik <= (secili == IW'(N - 1)) ? '0 : secili + IW'(1);
                    end else begin
                        oncelik <= oncelik;
                    end
                end
                default: begin
                    oncelik <= oncelik;
                end
            endcase
        end
    end

    // Response routing: only the latched winner sees its valid bit.
    always_comb begin
        yanit_gecerli = '0;
        if (durum == YANIT) begin
            yanit_gecerli[secili] = 1'b1;
        end else begin
            yanit_gecerli = '0;
        end
    end

    assign yanit_sonuc = sonuc_r;
    assign yanit_hata  = hata_r;
    assign mesgul      = (durum != BOS);

endmodule

// File: tb/tb_carpici_hakemi.sv
module tb_carpici_hakemi;

    localparam int N   = 4;
    localparam int Z   = 31;
    localparam int LAT = carpici_pkg::CARPICI_GECIKME;

    logic             clk = 1'b0;
    logic             rst_g;
    logic [N-1:0]     istek_gecerli;
    logic [N-1:0]     istek_hazir;
    logic [32*N-1:0]  istek_a;
    logic [32*N-1:0]  istek_b;
    logic [N-1:0]     a_is;
    logic [N-1:0]     b_is;
    logic [N-1:0]     yanit_gecerli;
    logic [N-1:0]     yanit_hazir;
    logic [63:0]      yanit_sonuc;
    logic             yanit_hata;
    logic             mesgul;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          k;
        logic [31:0] a;
        logic [31:0] b;
        logic        as;
        logic        bs;
        logic [63:0] exp;
    } vek_t;

    vek_t tablo[8];

    carpici_hakemi #(.ISTEKCI_SAYISI(N), .ZAMAN_ASIMI(Z)) dut (
        .clk              (clk),
        .rst_g            (rst_g),
        .istek_gecerli    (istek_gecerli),
        .istek_hazir      (istek_hazir),
        .istek_a          (istek_a),
        .istek_b          (istek_b),
        .istek_a_isaretli (a_is),
        .istek_b_isaretli (b_is),
        .yanit_gecerli    (yanit_gecerli),
        .yanit_hazir      (yanit_hazir),
        .yanit_sonuc      (yanit_sonuc),
        .yanit_hata       (yanit_hata),
        .mesgul           (mesgul)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: mathematical product of the operands interpreted per flag.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic as, input logic bs);
        longint ea, eb;
        ea = as ? longint'($signed(a)) : longint'({32'd0, a});
        eb = bs ? longint'($signed(b)) : longint'({32'd0, b});
        return 64'(ea * eb);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic wait_resp(input int k, input int t_acc, input logic [63:0] exp,
                             input logic exp_hata, input int lat, input string nm);
        int n;
        logic [N-1:0] oh;
        oh    = '0;
        oh[k] = 1'b1;
        n     = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (yanit_gecerli == '0 && n < 80);
        chk({nm, " latency"}, 64'(cyc - t_acc), 64'(lat));
        chk({nm, " yanit_gecerli"}, 64'(yanit_gecerli), 64'(oh));
        chk({nm, " sonuc"}, yanit_sonuc, exp);
        chk({nm, " hata"}, 64'(yanit_hata), 64'(exp_hata));
        chk({nm, " mesgul"}, 64'(mesgul), 64'd1);
    endtask

    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic as, input logic bs, input logic [63:0] exp,
                          input logic exp_hata, input int lat, input string nm);
        int n;
        int t;
        logic [N-1:0] oh;
        oh    = '0;
        oh[k] = 1'b1;
        @(negedge clk);
        istek_a[32*k +: 32] = a;
        istek_b[32*k +: 32] = b;
        a_is[k]             = as;
        b_is[k]             = bs;
        istek_gecerli[k]    = 1'b1;
        #1;
        n = 0;
        while (istek_hazir == '0 && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        chk({nm, " istek_hazir"}, 64'(istek_hazir), 64'(oh));
        t = cyc;
        @(posedge clk); #1;
        istek_gecerli[k] = 1'b0;
        wait_resp(k, t, exp, exp_hata, lat, nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_g         = 1'b0;
        istek_gecerli = '0;
        yanit_hazir   = '1;
        repeat (3) @(negedge clk);
        rst_g = 1'b1;
    endtask

    initial begin
        int n, t, t_resp, sessiz;
        logic [31:0] ra, rb;
        logic        ras, rbs;
        int          rk;
        logic [31:0] ea[N];
        logic [31:0] eb[N];
        logic        eas[N];
        logic        ebs[N];
        logic [N-1:0] oh;

        tablo[0] = '{0, 32'd3,          32'd5,          1'b0, 1'b0, 64'd15};
        tablo[1] = '{1, 32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b1, 1'b1, 64'd6};
        tablo[2] = '{2, 32'hFFFF_FFFE,  32'd4,          1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8};
        tablo[3] = '{3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001};
        tablo[4] = '{0, 32'h8000_0000,  32'h8000_0000,  1'b1, 1'b1, 64'h4000_0000_0000_0000};
        tablo[5] = '{1, 32'd0,          32'h1234_5678,  1'b1, 1'b1, 64'd0};
        tablo[6] = '{2, 32'hFFFF_FFFF,  32'd1,          1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF};
        tablo[7] = '{3, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1'b1, 64'hFFFF_FFFF_8000_0001};

        rst_g         = 1'b0;
        istek_gecerli = '0;
        istek_a       = '0;
        istek_b       = '0;
        a_is          = '0;
        b_is          = '0;
        yanit_hazir   = '1;
        repeat (2) @(negedge clk);
        chk("reset istek_hazir", 64'(istek_hazir), 64'd0);
        chk("reset yanit_gecerli", 64'(yanit_gecerli), 64'd0);
        chk("reset sonuc", yanit_sonuc, 64'd0);
        chk("reset hata", 64'(yanit_hata), 64'd0);
        chk("reset mesgul", 64'(mesgul), 64'd0);
        rst_g = 1'b1;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            run_op(tablo[i].k, tablo[i].a, tablo[i].b, tablo[i].as, tablo[i].bs,
                   tablo[i].exp, 1'b0, LAT, $sformatf("tablo%0d", i));
        end

        // Random operations against the arithmetic model
        for (int r = 0; r < 16; r++) begin
            rk  = int'($urandom_range(0, N - 1));
            ra  = $urandom;
            rb  = $urandom;
            ras = 1'($urandom_range(0, 1));
            rbs = 1'($urandom_range(0, 1));
            if (r % 4 == 0) ra = 32'h8000_0000;
            run_op(rk, ra, rb, ras, rbs, model(ra, rb, ras, rbs), 1'b0, LAT,
                   $sformatf("rastgele%0d", r));
        end

        // All requesters valid from reset: grant order 0,1,2,3,0 at 20-cycle spacing
        do_reset();
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            ea[k]  = $urandom;
            eb[k]  = $urandom;
            eas[k] = 1'($urandom_range(0, 1));
            ebs[k] = 1'($urandom_range(0, 1));
            istek_a[32*k +: 32] = ea[k];
            istek_b[32*k +: 32] = eb[k];
            a_is[k] = eas[k];
            b_is[k] = ebs[k];
        end
        istek_gecerli = '1;
        #1;
        t_resp = 0;
        for (int g = 0; g < 5; g++) begin
            int k;
            k  = g % N;
            oh = '0;
            oh[k] = 1'b1;
            n = 0;
            while (istek_hazir == '0 && n < 60) begin
                @(negedge clk); #1;
                n++;
            end
            chk($sformatf("rr grant%0d", g), 64'(istek_hazir), 64'(oh));
            if (g > 0) chk($sformatf("rr aralik%0d", g), 64'(cyc - t_resp), 64'd1);
            t = cyc;
            @(posedge clk); #1;
            if (g == 4) istek_gecerli = '0;
            wait_resp(k, t, model(ea[k], eb[k], eas[k], ebs[k]), 1'b0, LAT,
                      $sformatf("rr%0d", g));
            t_resp = cyc;
        end

        // Backpressure on requester 2 while requester 0 waits
        @(negedge clk);
        yanit_hazir = 4'b1011;
        istek_a[64 +: 32] = 32'd100;
        istek_b[64 +: 32] = 32'd200;
        a_is[2] = 1'b0;
        b_is[2] = 1'b0;
        istek_gecerli[2] = 1'b1;
        #1;
        chk("bp grant2", 64'(istek_hazir), 64'b0100);
        t = cyc;
        @(posedge clk); #1;
        istek_gecerli[2] = 1'b0;
        istek_a[0 +: 32] = 32'd9;
        istek_b[0 +: 32] = 32'd9;
        a_is[0] = 1'b0;
        b_is[0] = 1'b0;
        istek_gecerli[0] = 1'b1;
        wait_resp(2, t, 64'd20000, 1'b0, LAT, "bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk($sformatf("bp tut gecerli%0d", i), 64'(yanit_gecerli), 64'b0100);
            chk($sformatf("bp tut sonuc%0d", i), yanit_sonuc, 64'd20000);
            chk($sformatf("bp tut hazir%0d", i), 64'(istek_hazir), 64'd0);
            chk($sformatf("bp tut mesgul%0d", i), 64'(mesgul), 64'd1);
        end
        yanit_hazir = '1;
        @(negedge clk); #1;
        chk("bp sonra grant0", 64'(istek_hazir), 64'b0001);
        t = cyc;
        @(posedge clk); #1;
        istek_gecerli[0] = 1'b0;
        wait_resp(0, t, 64'd81, 1'b0, LAT, "bp sonra");

        // Reset in the middle of an operation
        @(negedge clk);
        istek_a[32 +: 32] = 32'd1234;
        istek_b[32 +: 32] = 32'd5678;
        a_is[1] = 1'b0;
        b_is[1] = 1'b0;
        istek_gecerli[1] = 1'b1;
        #1;
        chk("rst grant1", 64'(istek_hazir), 64'b0010);
        t = cyc;
        @(posedge clk); #1;
        istek_gecerli[1] = 1'b0;
        while (cyc < t + 8) @(negedge clk);
        #2;
        rst_g = 1'b0;
        #1;
        chk("rst async mesgul", 64'(mesgul), 64'd0);
        chk("rst async gecerli", 64'(yanit_gecerli), 64'd0);
        chk("rst async hazir", 64'(istek_hazir), 64'd0);
        chk("rst async sonuc", yanit_sonuc, 64'd0);
        chk("rst async hata", 64'(yanit_hata), 64'd0);
        repeat (2) @(negedge clk);
        rst_g = 1'b1;
        sessiz = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk); #1;
            if (yanit_gecerli != '0 || mesgul != 1'b0) sessiz++;
        end
        chk("rst sonra sessiz", 64'(sessiz), 64'd0);
        run_op(1, 32'd7, 32'd6, 1'b0, 1'b0, 64'd42, 1'b0, LAT, "rst sonra 7x6");

        // Timeout: the multiplier never signals completion
        force dut.carpici_bitti = 1'b0;
        run_op(3, 32'd11, 32'd13, 1'b0, 1'b0, 64'd0, 1'b1, Z + 2, "zaman asimi");
        release dut.carpici_bitti;
        run_op(3, 32'd11, 32'd13, 1'b0, 1'b0, 64'd143, 1'b0, LAT, "asim sonrasi");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
